// File: rtl/fifo_wr_rptr_monitor.sv
// Write-domain receiver for the async FIFO's gray read pointer.
// Synchronizes the pointer into wclk, decodes it to binary, derives the
// registered fill level / almost-full flag against the write pointer, and
// keeps sticky overflow and pointer-integrity status.
module fifo_wr_rptr_monitor #(
    parameter int PTR_SIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [PTR_SIZE-1:0] rptr_gray,
    input  logic [PTR_SIZE-1:0] wptr,
    input  logic                winc,
    input  logic                wfull,
    input  logic                wstat_clr,
    output logic [PTR_SIZE-1:0] sync_rd_ptr,
    output logic [PTR_SIZE-1:0] rbin_sync,
    output logic [PTR_SIZE-1:0] wlevel,
    output logic                walmost_full,
    output logic                wovf,
    output logic [7:0]          wovf_cnt,
    output logic                ptr_err
);

    localparam int DEPTH = 2 ** (PTR_SIZE - 1);
    localparam logic [PTR_SIZE-1:0] DEPTH_V = PTR_SIZE'(DEPTH);
    localparam logic [PTR_SIZE-1:0] AF_V    = PTR_SIZE'(AF_THRESH);

    // Gray to binary: bit i is the XOR of gray bits MSB..i.
    function automatic logic [PTR_SIZE-1:0] gray2bin(input logic [PTR_SIZE-1:0] g);
        logic [PTR_SIZE-1:0] b;
        b[PTR_SIZE-1] = g[PTR_SIZE-1];
        for (int i = PTR_SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_SIZE-1:0] sync_q [SYNC_STAGES];
    logic [PTR_SIZE-1:0] rbin_q;
    logic [PTR_SIZE-1:0] prev_q;
    logic [PTR_SIZE-1:0] wlevel_q;
    logic                walmost_full_q;
    logic                wovf_q,  wovf_d;
    logic [7:0]          wovf_cnt_q, wovf_cnt_d;
    logic                ptr_err_q, ptr_err_d;

    logic [PTR_SIZE-1:0] wbin;
    logic [PTR_SIZE-1:0] level_next;
    logic [PTR_SIZE-1:0] step_diff;
    logic                gray_step_bad;
    logic                level_bad;
    logic                ovf_event;

    // Synchronizer chain: stage 0 samples the raw gray pointer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_rd_ptr = sync_q[SYNC_STAGES-1];

    // Level and integrity terms; wrap-around falls out of the modular subtract.
    always_comb begin
        wbin          = gray2bin(wptr);
        level_next    = wbin - rbin_q;
        step_diff     = sync_rd_ptr ^ prev_q;
        // More than one bit set <=> clearing the lowest set bit leaves something.
        gray_step_bad = (step_diff & (step_diff - 1'b1)) != '0;
        level_bad     = level_next > DEPTH_V;
        ovf_event     = winc & wfull;
    end

    // Next-state for sticky status: a same-edge event or error beats the clear.
    always_comb begin
        wovf_d     = wovf_q;
        wovf_cnt_d = wovf_cnt_q;
        ptr_err_d  = ptr_err_q;
        if (wstat_clr) begin
            wovf_d     = 1'b0;
            wovf_cnt_d = '0;
            ptr_err_d  = 1'b0;
        end
        if (ovf_event) begin
            wovf_d = 1'b1;
            if (wstat_clr) begin
                wovf_cnt_d = 8'd1;
            end else if (wovf_cnt_q != 8'hFF) begin
                wovf_cnt_d = wovf_cnt_q + 8'd1;
            end
        end
        if (gray_step_bad || level_bad) begin
            ptr_err_d = 1'b1;
        end
    end

    // Decode, level, previous-pointer and status registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rbin_q         <= '0;
            prev_q         <= '0;
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
            wovf_cnt_q     <= '0;
            ptr_err_q      <= 1'b0;
        end else begin
            rbin_q         <= gray2bin(sync_rd_ptr);
            prev_q         <= sync_rd_ptr;
            wlevel_q       <= level_next;
            walmost_full_q <= level_next >= AF_V;
            wovf_q         <= wovf_d;
            wovf_cnt_q     <= wovf_cnt_d;
            ptr_err_q      <= ptr_err_d;
        end
    end

    assign rbin_sync    = rbin_q;
    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
    assign wovf         = wovf_q;
    assign wovf_cnt     = wovf_cnt_q;
    assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_fifo_wr_rptr_monitor.sv
// Directed bench for fifo_wr_rptr_monitor at default parameters
// (PTR_SIZE=4, DEPTH=8, SYNC_STAGES=2, AF_THRESH=6).
module tb_fifo_wr_rptr_monitor;

    logic       wclk;
    logic       wrst_n;
    logic [3:0] rptr_gray;
    logic [3:0] wptr;
    logic       winc;
    logic       wfull;
    logic       wstat_clr;
    logic [3:0] sync_rd_ptr;
    logic [3:0] rbin_sync;
    logic [3:0] wlevel;
    logic       walmost_full;
    logic       wovf;
    logic [7:0] wovf_cnt;
    logic       ptr_err;

    int n_vec = 0;
    int n_bad = 0;

    fifo_wr_rptr_monitor dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .rptr_gray    (rptr_gray),
        .wptr         (wptr),
        .winc         (winc),
        .wfull        (wfull),
        .wstat_clr    (wstat_clr),
        .sync_rd_ptr  (sync_rd_ptr),
        .rbin_sync    (rbin_sync),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .wovf         (wovf),
        .wovf_cnt     (wovf_cnt),
        .ptr_err      (ptr_err)
    );

    // Clock: 10 ns period.
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sync"}, 8'(sync_rd_ptr), 8'd0);
        check({tag, ".rbin"}, 8'(rbin_sync), 8'd0);
        check({tag, ".lvl"},  8'(wlevel), 8'd0);
        check({tag, ".af"},   8'(walmost_full), 8'd0);
        check({tag, ".ovf"},  8'(wovf), 8'd0);
        check({tag, ".cnt"},  wovf_cnt, 8'd0);
        check({tag, ".err"},  8'(ptr_err), 8'd0);
    endtask

    initial begin
        logic [3:0] g;
        wrst_n    = 1'b0;
        rptr_gray = '0;
        wptr      = '0;
        winc      = 1'b0;
        wfull     = 1'b0;
        wstat_clr = 1'b0;
        tick(2);
        check_all_zero("reset");
        wrst_n = 1'b1;
        tick(2);

        // Latency: wptr = gray(5), rptr = 0.
        wptr = 4'b0111;
        tick();
        check("lat.lvl5", 8'(wlevel), 8'd5);
        check("lat.af0", 8'(walmost_full), 8'd0);
        rptr_gray = 4'b0011;
        tick(2);
        check("lat.sync", 8'(sync_rd_ptr), 8'b0011);
        tick();
        check("lat.rbin", 8'(rbin_sync), 8'd2);
        check("lat.lvl_hold", 8'(wlevel), 8'd5);
        check("int.jump_err", 8'(ptr_err), 8'd1);
        tick();
        check("lat.lvl3", 8'(wlevel), 8'd3);
        wstat_clr = 1'b1;
        tick();
        wstat_clr = 1'b0;
        check("int.clr", 8'(ptr_err), 8'd0);

        // Wrap-around: wptr bin 1, rptr bin 9 then 12.
        wptr      = 4'b0001;
        rptr_gray = 4'b1101;
        tick(4);
        check("wrap.lvl8", 8'(wlevel), 8'd8);
        check("wrap.af1", 8'(walmost_full), 8'd1);
        rptr_gray = 4'b1010;
        tick(4);
        check("wrap.lvl5", 8'(wlevel), 8'd5);
        check("wrap.af0", 8'(walmost_full), 8'd0);
        wstat_clr = 1'b1;
        tick();
        wstat_clr = 1'b0;
        check("wrap.clr", 8'(ptr_err), 8'd0);

        // Almost-full boundary: level 5 -> 6 -> 5.
        wptr = 4'b0011;
        tick();
        check("af.lvl6", 8'(wlevel), 8'd6);
        check("af.on", 8'(walmost_full), 8'd1);
        wptr = 4'b0001;
        tick();
        check("af.lvl5", 8'(wlevel), 8'd5);
        check("af.off", 8'(walmost_full), 8'd0);

        // Legal gray walk 0..15 must not raise ptr_err.
        wptr      = '0;
        rptr_gray = '0;
        tick(5);
        wstat_clr = 1'b1;
        tick();
        wstat_clr = 1'b0;
        check("walk.pre_err", 8'(ptr_err), 8'd0);
        check("walk.pre_lvl", 8'(wlevel), 8'd0);
        for (int i = 0; i < 16; i++) begin
            g         = 4'(i ^ (i >> 1));
            rptr_gray = g;
            wptr      = g;
            tick();
        end
        tick(4);
        check("walk.err", 8'(ptr_err), 8'd0);
        check("walk.lvl", 8'(wlevel), 8'd0);
        check("walk.sync", 8'(sync_rd_ptr), 8'b1000);
        check("walk.rbin", 8'(rbin_sync), 8'd15);

        // Overflow: three dropped writes.
        check("ovf.idle", 8'(wovf), 8'd0);
        wfull = 1'b1;
        repeat (3) begin
            winc = 1'b1;
            tick();
            winc = 1'b0;
            tick();
        end
        check("ovf.flag", 8'(wovf), 8'd1);
        check("ovf.cnt3", wovf_cnt, 8'd3);
        wfull = 1'b0;
        winc  = 1'b1;
        tick();
        winc = 1'b0;
        check("ovf.notfull", wovf_cnt, 8'd3);
        wfull = 1'b1;
        winc  = 1'b1;
        tick(300);
        winc = 1'b0;
        check("ovf.sat", wovf_cnt, 8'd255);
        winc      = 1'b1;
        wstat_clr = 1'b1;
        tick();
        winc = 1'b0;
        check("ovf.clr_evt_flag", 8'(wovf), 8'd1);
        check("ovf.clr_evt_cnt", wovf_cnt, 8'd1);
        tick();
        wstat_clr = 1'b0;
        check("ovf.clr_flag", 8'(wovf), 8'd0);
        check("ovf.clr_cnt", wovf_cnt, 8'd0);
        winc = 1'b1;
        tick();
        winc = 1'b0;
        check("ovf.again", wovf_cnt, 8'd1);

        // Asynchronous reset mid-run with nonzero state.
        wptr = 4'b0010;
        tick();
        check("rst.pre_lvl", 8'(wlevel), 8'd4);
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        tick();
        wrst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_rptr_monitor.md
Name: fifo_wr_rptr_monitor

Overview:
- Write-clock-domain receiver for the gray-coded read pointer coming back from the async FIFO read side.
- Synchronizes the pointer into wclk and decodes it to binary.
- Computes the registered fill level and almost-full flag against the write pointer.
- Flags overflow attempts and illegal pointer behaviour.
- Sits beside the FIFO write controller and feeds its sync_rd_ptr input.

Parameters:
- PTR_SIZE, 4, pointer width; FIFO depth DEPTH = 2^(PTR_SIZE-1).
- SYNC_STAGES, 2, flop stages in the read-pointer synchronizer (legal values 2..4).
- AF_THRESH, 6, fill level at or above which walmost_full asserts (legal range 1..DEPTH).

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  reset; asynchronous, active-low
- rptr_gray  in  PTR_SIZE  gray read pointer, driven from read domain (asynchronous to wclk)
- wptr  in  PTR_SIZE  gray write pointer from write controller (wclk domain, registered)
- winc  in  1  write request from producer
- wfull  in  1  registered full flag from write controller
- wstat_clr  in  1  synchronous clear of sticky status and counter
- sync_rd_ptr  out  PTR_SIZE  synchronized gray read pointer
- rbin_sync  out  PTR_SIZE  binary-decoded synchronized read pointer
- wlevel  out  PTR_SIZE  registered FIFO fill level, 0..DEPTH
- walmost_full  out  1  registered, high when the level is >= AF_THRESH
- wovf  out  1  sticky overflow flag
- wovf_cnt  out  8  saturating count of overflow attempts
- ptr_err  out  1  sticky pointer-integrity error

Behaviour:
- Reset (wrst_n low, asynchronous): all synchronizer stages, the previous-pointer register and every output go to 0. Release is synchronous to wclk.
- Synchronizer:
  - Chain of SYNC_STAGES flops; stage 0 samples rptr_gray. Only gray-coded values may enter the chain.
  - sync_rd_ptr is the last stage. A stable rptr_gray change appears on sync_rd_ptr after SYNC_STAGES wclk edges.
- Decode: rbin_sync is the registered gray-to-binary of sync_rd_ptr (bit i = XOR of gray bits PTR_SIZE-1..i). Latency is 1 edge after sync_rd_ptr.
- Level:
  - wbin = combinational gray-to-binary of wptr.
  - wlevel <= (wbin - rbin_sync) modulo 2^PTR_SIZE, registered, 1 edge after either input.
  - Pointer wrap-around is handled purely by the modular subtraction, with no special case.
  - walmost_full <= (level_next >= AF_THRESH), updated on the same edge as wlevel.
- Overflow:
  - An event is an edge where winc=1 and wfull=1 (a dropped write).
  - On each event, wovf <= 1 and wovf_cnt increments, saturating at 255.
  - When wstat_clr=1 the clear takes effect on that same edge: wovf <= 0, wovf_cnt <= 0, ptr_err <= 0.
  - If wstat_clr and an overflow event fall on the same edge, the event wins: wovf=1 and wovf_cnt=1.
- Pointer integrity:
  - A previous-value register holds sync_rd_ptr from the prior edge.
  - If (sync_rd_ptr XOR previous) has more than one bit set, ptr_err <= 1 (illegal gray step).
  - ptr_err <= 1 also if the computed level exceeds DEPTH.
  - wstat_clr clears ptr_err, but an error detected on the same edge keeps it at 1.
- The level is conservative: the read pointer is stale by SYNC_STAGES+1 edges, so the level may over-report but never under-reports.
- wfull is not generated here; this block only observes it.
- Reset mid-operation: all state clears immediately. The first post-reset samples compare against 0, so reset both FIFO domains together. Pointers that are nonzero after reset may legitimately set ptr_err.

Test Plan:
- Reset, defaults (PTR_SIZE=4, DEPTH=8, SYNC_STAGES=2): assert wrst_n low mid-run -> every output is 0 immediately, asynchronously of wclk.
- Latency: wptr gray for 5 (0111) with rptr_gray=0 -> wlevel=5 one edge later. Then rptr_gray=0011 (binary 2) -> sync_rd_ptr=0011 after 2 edges, rbin_sync=2 after 3, wlevel=3 after 4.
- Wrap-around: wptr binary 1 (0001), rptr binary 9 (1101) -> wlevel=8, walmost_full=1. Then rptr binary 12 -> wlevel=5, walmost_full=0 (AF_THRESH=6).
- Almost-full boundary: step the level 5->6->5 -> walmost_full goes 0->1->0 on the same edges as wlevel.
- Overflow: hold wfull=1 and pulse winc 3 times -> wovf=1, wovf_cnt=3. Then 300 events -> wovf_cnt=255. Then wstat_clr on an edge together with an event -> wovf=1, wovf_cnt=1.
- Integrity: rptr_gray jumps 0000->0011 -> ptr_err=1 one edge after it reaches sync_rd_ptr. wstat_clr -> ptr_err=0. A legal gray sequence 0..15 -> ptr_err stays 0.
